mul_scheduler: RTL and testbench

//  Shares one iterative shift-add multiplier (A_W x B_W) between NREQ requesters.

---
 rtl/mul_scheduler_pkg.sv | 24 ++
 rtl/mul_scheduler_shift_add_core.sv | 67 ++++++
 rtl/mul_scheduler.sv | 129 ++++++++++++
 tb/tb_mul_scheduler.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mul_scheduler_pkg.sv
// ============================================================================
// Module      : mul_scheduler_pkg
// Description : Shared state encoding and sizing helper for the multiply
//               scheduler and its shift-add core.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mul_scheduler_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Width of a requester index; never zero so single-bit ports stay legal.
    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/mul_scheduler_shift_add_core.sv
// ============================================================================
// Module      : shift_add_core
// Description : Bit-serial unsigned shift-add multiplier datapath.
//               Optional MUL_EARLY_EXIT_EN ends the run once no multiplier
//               bits remain.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module shift_add_core
    import mul_scheduler_pkg::*;
#(
    parameter int A_W = 8,
    parameter int B_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             step,
    input  logic [A_W-1:0]   a,
    input  logic [B_W-1:0]   b,
    output logic             last,
    output logic [A_W+B_W-1:0] acc
);

    localparam int P_W   = A_W + B_W;
    localparam int CNT_W = $clog2(B_W + 1);

    logic [P_W-1:0]   r_a_sh;
    logic [P_W-1:0]   r_acc;
    logic [B_W-1:0]   r_b_sh;
    logic [CNT_W-1:0] r_cnt;
    logic [P_W-1:0]   w_acc_nxt;

    // acc presents the value after the current step so the final product can
    // be captured on the same edge that retires the last step.
    assign w_acc_nxt = r_b_sh[0] ? (r_acc + r_a_sh) : r_acc;
    assign acc       = w_acc_nxt;

`ifdef MUL_EARLY_EXIT_EN
    assign last = (r_cnt == CNT_W'(B_W - 1)) || ((r_b_sh >> 1) == '0);
`else
    assign last = (r_cnt == CNT_W'(B_W - 1));
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a_sh <= '0;
            r_b_sh <= '0;
            r_acc  <= '0;
            r_cnt  <= '0;
        end else if (load) begin
            r_a_sh <= {{B_W{1'b0}}, a};
            r_b_sh <= b;
            r_acc  <= '0;
            r_cnt  <= '0;
        end else if (step) begin
            r_acc  <= w_acc_nxt;
            r_a_sh <= r_a_sh << 1;
            r_b_sh <= r_b_sh >> 1;
            r_cnt  <= r_cnt + 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/mul_scheduler.sv
// ============================================================================
// Module      : mul_scheduler
// Description : Round-robin sharing of one shift-add multiplier among NREQ
//               requesters with req/gnt/done handshake.
//               Build option: MUL_EARLY_EXIT_EN (early RUN termination).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mul_scheduler
    import mul_scheduler_pkg::*;
#(
    parameter int A_W  = 8,
    parameter int B_W  = 4,
    parameter int NREQ = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NREQ-1:0]             req,
    input  logic [NREQ*A_W-1:0]         a_in,
    input  logic [NREQ*B_W-1:0]         b_in,
    output logic [NREQ-1:0]             gnt,
    output logic                        busy,
    output logic                        done,
    output logic [id_width(NREQ)-1:0]   done_id,
    output logic [A_W+B_W-1:0]          out
);

    localparam int ID_W = id_width(NREQ);

    state_t             r_state;
    logic [ID_W-1:0]    r_rr_ptr;
    logic [ID_W-1:0]    r_id;

    logic               w_found;
    logic [ID_W-1:0]    w_k;
    logic [ID_W-1:0]    w_rr_next;
    logic               w_start;
    logic               w_step;
    logic               w_last;
    logic [A_W-1:0]     w_a_sel;
    logic [B_W-1:0]     w_b_sel;
    logic [A_W+B_W-1:0] w_acc;

    // Circular search for the first pending request at or after rr_ptr.
    always_comb begin
        w_found = 1'b0;
        w_k     = '0;
        for (int j = 0; j < NREQ; j++) begin
            if (!w_found && req[(int'(r_rr_ptr) + j) % NREQ]) begin
                w_found = 1'b1;
                w_k     = ID_W'((int'(r_rr_ptr) + j) % NREQ);
            end
        end
    end

    assign w_start   = (r_state == S_IDLE) && w_found;
    assign w_step    = (r_state == S_RUN);
    assign w_rr_next = (int'(w_k) == NREQ - 1) ? '0 : w_k + 1'b1;
    assign w_a_sel   = a_in[int'(w_k)*A_W +: A_W];
    assign w_b_sel   = b_in[int'(w_k)*B_W +: B_W];

    // gnt marks the cycle whose operands are captured, so it cannot be delayed.
    always_comb begin
        gnt = '0;
        if (w_start && !rst) begin
            gnt[w_k] = 1'b1;
        end
    end

    shift_add_core #(
        .A_W (A_W),
        .B_W (B_W)
    ) u_core (
        .clk  (clk),
        .rst  (rst),
        .load (w_start),
        .step (w_step),
        .a    (w_a_sel),
        .b    (w_b_sel),
        .last (w_last),
        .acc  (w_acc)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_rr_ptr <= '0;
            r_id     <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            done_id  <= '0;
            out      <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (w_found) begin
                        r_state  <= S_RUN;
                        r_id     <= w_k;
                        r_rr_ptr <= w_rr_next;
                        busy     <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (w_last) begin
                        r_state <= S_DONE;
                        done    <= 1'b1;
                        out     <= w_acc;
                        done_id <= r_id;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    done    <= 1'b0;
                    busy    <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    done    <= 1'b0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mul_scheduler.sv
// ============================================================================
// Module      : tb_mul_scheduler
// Description : Scoreboard bench for mul_scheduler (default and
//               MUL_EARLY_EXIT_EN builds).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mul_scheduler;

    localparam int A_W  = 8;
    localparam int B_W  = 4;
    localparam int NREQ = 2;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [NREQ-1:0]       req;
    logic [NREQ*A_W-1:0]   a_in;
    logic [NREQ*B_W-1:0]   b_in;
    logic [NREQ-1:0]       gnt;
    logic                  busy;
    logic                  done;
    logic [0:0]            done_id;
    logic [A_W+B_W-1:0]    out;

    int checks     = 0;
    int errors     = 0;
    int cyc        = 0;
    int done_count = 0;

    typedef struct {
        int id;
        int prod;
        int due;
    } exp_t;

    exp_t sb[$];

    int rr_gnt[3]  = '{1, 2, 1};
    int rr_id[3]   = '{0, 1, 0};
    int rr_prod[3] = '{15, 63, 15};
    int rr_b[3]    = '{5, 9, 5};

    mul_scheduler #(
        .A_W  (A_W),
        .B_W  (B_W),
        .NREQ (NREQ)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .a_in    (a_in),
        .b_in    (b_in),
        .gnt     (gnt),
        .busy    (busy),
        .done    (done),
        .done_id (done_id),
        .out     (out)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    // Cycles from grant to done for a given multiplier operand.
    function automatic int lat(input logic [3:0] b);
`ifdef MUL_EARLY_EXIT_EN
        int m;
        m = 0;
        for (int i = 0; i < 4; i++) begin
            if (b[i]) m = i + 1;
        end
        if (m < 1) m = 1;
        return 1 + m;
`else
        return B_W + 1;
`endif
    endfunction

    // Monitor: every done pops one expected result.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && done) begin
            done_count++;
            if (sb.size() == 0) begin
                fail("unexpected_done");
            end else begin
                e = sb.pop_front();
                chk("out", int'(out), e.prod);
                chk("done_id", int'(done_id), e.id);
                chk("done_cycle", cyc, e.due);
                chk("busy_at_done", int'(busy), 1);
            end
        end
    end

    task automatic wait_gnt(output int ok);
        ok = 0;
        for (int w = 0; w < 40; w++) begin
            if (gnt != '0) begin
                ok = 1;
                break;
            end
            @(negedge clk);
            #1;
        end
        if (ok == 0) fail("gnt_timeout");
    endtask

    task automatic do_op(input int id, input logic [7:0] a, input logic [3:0] b, input int prod);
        int   ok;
        exp_t e;
        @(negedge clk);
        req[id]           = 1'b1;
        a_in[id*A_W +: A_W] = a;
        b_in[id*B_W +: B_W] = b;
        #1;
        wait_gnt(ok);
        if (ok != 0) begin
            chk("gnt", int'(gnt), 1 << id);
            e.id   = id;
            e.prod = prod;
            e.due  = cyc + lat(b);
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        req[id] = 1'b0;
    endtask

    task automatic drain();
        for (int w = 0; w < 60 && sb.size() != 0; w++) @(negedge clk);
        if (sb.size() != 0) begin
            fail("drain_timeout");
            sb.delete();
        end
        @(negedge clk);
    endtask

    task automatic reset_dut();
        @(negedge clk);
        rst = 1'b1;
        sb.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog_timeout (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int ok;
        int last_g;
        int dc;
        exp_t e;

        rst  = 1'b1;
        req  = '0;
        a_in = '0;
        b_in = '0;
        repeat (2) @(negedge clk);
        chk("rst_gnt", int'(gnt), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_done_id", int'(done_id), 0);
        chk("rst_out", int'(out), 0);
        req = 2'b01;
        #1;
        chk("rst_gnt_with_req", int'(gnt), 0);
        req = '0;
        @(negedge clk);
        rst = 1'b0;

        // Single multiply after reset
        do_op(0, 8'd200, 4'd13, 2600);
        drain();

        // Both requesters held: alternating grants from a fresh rr_ptr
        reset_dut();
        @(negedge clk);
        a_in = {8'd7, 8'd3};
        b_in = {4'd9, 4'd5};
        req  = 2'b11;
        #1;
        last_g = 0;
        for (int g = 0; g < 3; g++) begin
            wait_gnt(ok);
            if (ok == 0) break;
            chk("rr_gnt", int'(gnt), rr_gnt[g]);
            if (g > 0) chk("gnt_spacing", cyc - last_g, lat(4'(rr_b[g-1])) + 1);
            last_g = cyc;
            e.id   = rr_id[g];
            e.prod = rr_prod[g];
            e.due  = cyc + lat(4'(rr_b[g]));
            sb.push_back(e);
            @(posedge clk);
            #1;
            if (g == 2) begin
                req = '0;
            end else begin
                @(negedge clk);
                #1;
            end
        end
        req = '0;
        drain();

        // Zero operand and maximum operands
        do_op(0, 8'd0, 4'd9, 0);
        do_op(0, 8'd255, 4'd15, 3825);
        drain();

        // Reset in the middle of RUN aborts the operation
        @(negedge clk);
        a_in[15:8] = 8'd10;
        b_in[7:4]  = 4'd10;
        req        = 2'b10;
        #1;
        wait_gnt(ok);
        chk("abort_gnt", int'(gnt), 2);
        @(posedge clk);
        #1;
        req = '0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        dc  = done_count;
        #1;
        chk("abort_busy", int'(busy), 0);
        chk("abort_done", int'(done), 0);
        chk("abort_out", int'(out), 0);
        chk("abort_done_id", int'(done_id), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        chk("no_done_after_abort", done_count, dc);
        do_op(1, 8'd10, 8'd10 > 0 ? 4'd10 : 4'd0, 100);
        drain();

        // Sweep of operand pairs
        for (int a = 0; a < 256; a += 2) begin
            for (int b = 0; b < 16; b += 3) begin
                do_op((a / 2) % 2, 8'(a), 4'(b), a * b);
            end
        end
        drain();

        // Latency dependence on the multiplier operand
        do_op(0, 8'd77, 4'd0, 0);
        do_op(1, 8'd50, 4'd2, 100);
        do_op(0, 8'd13, 4'd8, 104);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
